// File: rtl/bus_arbiter_8way16.sv
// bus_arbiter_8way16: round-robin arbiter that funnels eight 16-bit requesters
// into one registered output word with a valid/ready handshake. The registered
// source select (sel) doubles as the source ID of the word held in out.
module bus_arbiter_8way16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  req,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
  output logic [7:0]  ack,
  output logic [15:0] out,
  output logic [2:0]  sel,
  output logic        out_valid,
  input  logic        out_ready
);

  // The output register is either empty or holding an unconsumed word.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  ptr_q;
  logic [2:0]  ptr_d;
  logic [15:0] out_q;
  logic [15:0] out_d;
  logic [2:0]  sel_q;
  logic [2:0]  sel_d;

  logic        can_load_s;
  logic        grant_s;
  logic        hit_s;
  logic [2:0]  winner_s;
  logic [15:0] win_data_s;
  logic [7:0]  ack_s;

  // Scan ptr, ptr+1, ... ptr+7 (mod 8) and return {found, index} of the first
  // requester with req set. The loop runs downwards so the lowest offset wins.
  function automatic logic [3:0] pick_winner(input logic [7:0] req_v,
                                             input logic [2:0] ptr_v);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr_v + k[2:0];
      if (req_v[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Round-robin winner search, purely from req and the priority pointer.
  always_comb begin
    logic [3:0] pick;
    pick     = pick_winner(req, ptr_q);
    hit_s    = pick[3];
    winner_s = pick[2:0];
  end

  // Source mux: word of the current winner (same select an 8-way mux uses).
  always_comb begin
    win_data_s = 16'h0000;
    case (winner_s)
      3'd0:    win_data_s = a;
      3'd1:    win_data_s = b;
      3'd2:    win_data_s = c;
      3'd3:    win_data_s = d;
      3'd4:    win_data_s = e;
      3'd5:    win_data_s = f;
      3'd6:    win_data_s = g;
      3'd7:    win_data_s = h;
      default: win_data_s = 16'h0000;
    endcase
  end

  // A load is possible when the register is empty or is being drained now;
  // nothing is granted while reset is asserted so a reset cycle never acks.
  always_comb begin
    if (state_q == ST_EMPTY) begin
      can_load_s = 1'b1;
    end else begin
      can_load_s = out_ready;
    end
    grant_s = can_load_s & hit_s & ~reset;
  end

  // State register: handshake state, priority pointer and output word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      ptr_q   <= 3'd0;
      out_q   <= 16'h0000;
      sel_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      out_q   <= out_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state logic: capture on grant, empty on drain-without-request,
  // otherwise hold (covers the stalled FULL case and idle EMPTY cycles).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    out_d   = out_q;
    sel_d   = sel_q;
    case (state_q)
      ST_EMPTY: begin
        if (grant_s) begin
          state_d = ST_FULL;
          ptr_d   = winner_s + 3'd1;
          out_d   = win_data_s;
          sel_d   = winner_s;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (grant_s) begin
          state_d = ST_FULL;
          ptr_d   = winner_s + 3'd1;
          out_d   = win_data_s;
          sel_d   = winner_s;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Output logic: one-hot acknowledge in the same cycle as the capture.
  always_comb begin
    if (grant_s) begin
      ack_s = 8'd1 << winner_s;
    end else begin
      ack_s = 8'd0;
    end
  end

  assign ack       = ack_s;
  assign out       = out_q;
  assign sel       = sel_q;
  assign out_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_bus_arbiter_8way16.sv
// Self-checking bench for bus_arbiter_8way16: a reference model predicts ack
// and the output register each cycle, and every granted word is queued and
// compared when the downstream side consumes it.
module tb_bus_arbiter_8way16;

  logic        clk;
  logic        reset;
  logic [7:0]  req;
  logic [15:0] dat [8];
  logic [7:0]  ack;
  logic [15:0] out;
  logic [2:0]  sel;
  logic        out_valid;
  logic        out_ready;

  int          n_vec;
  int          n_err;

  // Reference model state
  logic        m_valid;
  logic [15:0] m_out;
  logic [2:0]  m_sel;
  logic [2:0]  m_ptr;
  logic [18:0] sb [$];
  int          waitc [8];
  logic [7:0]  last_ack;

  bus_arbiter_8way16 dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .a         (dat[0]),
    .b         (dat[1]),
    .c         (dat[2]),
    .d         (dat[3]),
    .e         (dat[4]),
    .f         (dat[5]),
    .g         (dat[6]),
    .h         (dat[7]),
    .ack       (ack),
    .out       (out),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check the combinational
  // ack before the rising edge, then check the registered outputs after it.
  task automatic step(input logic [7:0] r, input logic rdy, input logic rst);
    logic [7:0]  e_ack;
    logic [2:0]  w;
    logic [2:0]  j;
    logic        hit;
    logic [18:0] ent;
    @(negedge clk);
    reset     = rst;
    req       = r;
    out_ready = rdy;
    #1;
    e_ack = 8'd0;
    hit   = 1'b0;
    w     = 3'd0;
    if (!rst && (!m_valid || rdy)) begin
      for (int k = 0; k < 8; k++) begin
        j = 3'((int'(m_ptr) + k) % 8);
        if (!hit && r[j]) begin
          hit = 1'b1;
          w   = j;
        end
      end
    end
    if (hit) e_ack[w] = 1'b1;
    chk("ack", ack, e_ack);
    last_ack = ack;
    chk("valid_pre", out_valid, m_valid);
    if (!rst && m_valid && rdy) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        ent = sb.pop_front();
        chk("sb_out", out, ent[15:0]);
        chk("sb_sel", sel, ent[18:16]);
      end
    end
    // Fairness, measured on the acks the DUT actually gives.
    for (int i = 0; i < 8; i++) begin
      if (!r[i] || rst) begin
        waitc[i] = 0;
      end else if (ack[i]) begin
        chk("fair", waitc[i] <= 7, 1);
        waitc[i] = 0;
      end else if (ack != 8'd0) begin
        waitc[i]++;
      end
    end
    if (rst) begin
      m_valid = 1'b0;
      m_out   = 16'h0000;
      m_sel   = 3'd0;
      m_ptr   = 3'd0;
      sb.delete();
    end else if (hit) begin
      sb.push_back({w, dat[w]});
      m_valid = 1'b1;
      m_out   = dat[w];
      m_sel   = w;
      m_ptr   = w + 3'd1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("valid", out_valid, m_valid);
    chk("out", out, m_out);
    chk("sel", sel, m_sel);
    chk("ptr", dut.ptr_q, m_ptr);
  endtask

  initial begin
    logic [7:0] rr;
    n_vec = 0;
    n_err = 0;
    m_valid = 1'b0;
    m_out = 16'h0000;
    m_sel = 3'd0;
    m_ptr = 3'd0;
    last_ack = 8'd0;
    reset = 1'b1;
    req = 8'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dat[i] = 16'h0000;
      waitc[i] = 0;
    end

    // Reset state
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_out", out, 16'h0000);

    // Single request from c
    dat[2] = 16'hBEEF;
    step(8'h04, 1'b1, 1'b0);
    chk("t1_ack", last_ack, 8'h04);
    chk("t1_out", out, 16'hBEEF);
    chk("t1_sel", sel, 3'd2);
    step(8'h00, 1'b1, 1'b0);
    chk("t1_empty", out_valid, 1'b0);
    chk("t1_ptr", dut.ptr_q, 3'd3);

    // All eight requesting: strict rotation with wrap
    step(8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) dat[i] = 16'(i);
    for (int n = 0; n < 10; n++) begin
      step(8'hFF, 1'b1, 1'b0);
      chk("rr_seq", out, 16'(n % 8));
    end
    step(8'h00, 1'b1, 1'b0);

    // Wrap from ptr=5 to requesters 0 then 1
    dat[4] = 16'h4444;
    step(8'h10, 1'b1, 1'b0);
    chk("t3_ptr5", dut.ptr_q, 3'd5);
    dat[0] = 16'hA000;
    dat[1] = 16'hB001;
    step(8'h03, 1'b1, 1'b0);
    chk("t3_first", sel, 3'd0);
    step(8'h02, 1'b1, 1'b0);
    chk("t3_second", sel, 3'd1);
    step(8'h00, 1'b1, 1'b0);
    chk("t3_ptr2", dut.ptr_q, 3'd2);

    // Backpressure stall with all requesting
    for (int i = 0; i < 8; i++) dat[i] = 16'h1100 + 16'(i);
    step(8'hFF, 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) begin
      step(8'hFF, 1'b0, 1'b0);
      chk("stall_ack", last_ack, 8'h00);
      chk("stall_out", out, 16'h1102);
    end
    step(8'hFF, 1'b1, 1'b0);
    chk("unstall_ack", last_ack, 8'h08);

    // Reset while FULL with requests pending
    step(8'h01, 1'b0, 1'b1);
    chk("mrst_ack", last_ack, 8'h00);
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_sel", sel, 3'd0);
    step(8'h01, 1'b1, 1'b0);
    chk("mrst_regrant", last_ack, 8'h01);
    step(8'h00, 1'b1, 1'b0);

    // Randomised traffic honouring the requester contract
    rr = 8'h00;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 8; i++) begin
        if (last_ack[i]) begin
          rr[i] = 1'($urandom_range(0, 1));
          if (rr[i]) dat[i] = 16'($urandom);
        end else if (!rr[i] && ($urandom_range(0, 3) == 0)) begin
          rr[i] = 1'b1;
          dat[i] = 16'($urandom);
        end
      end
      step(rr, ($urandom_range(0, 3) != 0), 1'b0);
    end
    for (int n = 0; n < 4; n++) step(8'h00, 1'b1, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_8way16.md
# bus_arbiter_8way16

Round-robin arbiter that shares one 16-bit output channel between eight requesters. Each cycle the block can pick one pending requester, capture its word into a single output register and acknowledge it. It then presents the word downstream with a valid/ready handshake. It sits in front of any shared 16-bit consumer (memory write port, output latch) and drives the same 3-bit source select that an 8-way 16-bit mux uses, so `sel` doubles as the source ID.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  8  `req[i]`=1: requester i holds a valid word on its data input.
- `a`,`b`,`c`,`d`,`e`,`f`,`g`,`h`  in  16 each  data from requesters 0..7.
- `ack`  out  8  one-hot or zero; `ack[i]`=1 means requester i's word is captured at this clock edge.
- `out`  out  16  registered word presented downstream.
- `sel`  out  3  registered source ID of `out` (0=a … 7=h).
- `out_valid`  out  1  `out`/`sel` hold an unconsumed word.
- `out_ready`  in  1  downstream accepts `out` at this edge when `out_valid`=1.

## Operation
- State:
  - `ptr[2:0]` is the round-robin priority pointer.
  - `out`, `sel` and `out_valid` form the output register.
- Two states, held in `out_valid`:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- `can_load` = EMPTY | (FULL & `out_ready`).
- Winner selection: the first i with `req[i]`=1, scanning `ptr`, `ptr`+1, …, `ptr`+7 mod 8. This is purely combinational from `req` and `ptr`.
- `ack` = one-hot(winner) when `can_load` & |`req`; otherwise `ack`=0. `ack` is combinational and asserted in the same cycle the capture happens.
- At an edge with `ack`≠0:
  - `out`←winner's data; `sel`←winner; `out_valid`←1.
  - `ptr`←winner+1 mod 8 (7 wraps to 0).
- At an edge with FULL & `out_ready` & `req`=0: `out_valid`←0. `out` and `sel` keep their last values.
- At an edge with FULL & !`out_ready`: all state is held and `ack`=0, regardless of `req`.
- With `out_valid`=0, `out_ready` is ignored.
- Requester contract: a requester holds `req[i]` high with stable data until it sees `ack[i]`. After `ack[i]`, the requester may present its next word (keep `req[i]` high) or drop `req[i]`.
- Fairness: a requester holding `req` high is granted within at most 8 consecutive grants. With all 8 requesting, grant order is strictly ptr, ptr+1, …
- Reset (any cycle, including mid-transfer):
  - `out`=0, `sel`=0, `out_valid`=0, `ptr`=0.
  - `ack`=0 during the reset cycle.
  - A word held at reset is discarded, not delivered.

## Timing
- Latency: `req[i]` rises at cycle n with the block EMPTY → `ack[i]`=1 in cycle n → `out_valid`=1 and `out`=data in cycle n+1.
- Throughput: one word per cycle while `out_ready` stays 1 and `req`≠0. Back-to-back load and unload occur in the same edge.
- Backpressure: `out_ready`=0 stalls the block with zero `ack` and no loss. The word in `out` is stable until consumed.
- `ptr` advances only on a grant, never on idle cycles.
- Drop case: `req` that falls without an `ack` is a requester violation. The block only guarantees that no `ack` is given for it.

## Test plan
- Reset, then `req`=8'b0000_0100 with `c`=16'hBEEF and `out_ready`=1 → `ack`=8'b0000_0100 in the same cycle. The next cycle shows `out`=BEEF, `sel`=2, `out_valid`=1, and the cycle after shows `out_valid`=0 (`req` dropped). `ptr`=3.
- All 8 `req` held high, data a..h = 0x0000..0x0007, `out_ready`=1 → `out` sequence 0,1,…,7,0,1 on consecutive cycles. `sel` tracks it, and the wrap 7→0 is exercised.
- `ptr`=5 with `req`=8'b0000_0011 → requester 0 granted first, then 1; `ptr` ends at 2.
- FULL with `out_ready`=0 for 4 cycles while `req`=8'hFF → `ack`=0 and `out`/`sel` unchanged throughout. When `out_ready` returns to 1, the next winner loads in that same cycle.
- Assert `reset` while FULL with `req` pending → next cycle `out_valid`=0, `out`=0, `sel`=0, `ptr`=0. `ack`=0 during reset, then `ack`=8'b0000_0001 after release if `req[0]`=1.
- Randomised `req`/`out_ready` with a scoreboard → every acked word appears on `out` exactly once, in ack order. No requester waits more than 8 grants.
